shift_add_seq_ctrl: RTL and testbench

- Controller FSM that sequences a shift-and-add multiplier built from the team's shift-register and adder building blocks.
- Issues one-cycle LOAD, ADD and SHIFT strobes to the multiplier shift register and the accumulator, and counts shifted bits.
- Provides a level start/done handshake to the host logic.
- Runs on posedge clk. The datapath registers act on negedge, so every strobe is stable across the datapath's sampling edge. Datapath status is valid at the next posedge.

---
 rtl/shift_add_seq_ctrl_if.sv | 43 ++++
 rtl/shift_add_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_shift_add_seq_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_seq_ctrl_if.sv
// Host/datapath handshake bundle for the shift-and-add sequencer.
// The controller connects through the slave modport; the host logic and
// multiplier datapath together form the master side.
interface shift_add_seq_ctrl_if #(
    parameter int CNT_WIDTH = 4
) ();
    logic                 in_START;
    logic                 in_LSB;
    logic                 in_ZERO;
    logic                 out_LOAD;
    logic                 out_CLR_ACC;
    logic                 out_ADD;
    logic                 out_SHIFT;
    logic                 out_BUSY;
    logic                 out_DONE;
    logic [CNT_WIDTH-1:0] out_COUNT;

    modport master (
        output in_START,
        output in_LSB,
        output in_ZERO,
        input  out_LOAD,
        input  out_CLR_ACC,
        input  out_ADD,
        input  out_SHIFT,
        input  out_BUSY,
        input  out_DONE,
        input  out_COUNT
    );

    modport slave (
        input  in_START,
        input  in_LSB,
        input  in_ZERO,
        output out_LOAD,
        output out_CLR_ACC,
        output out_ADD,
        output out_SHIFT,
        output out_BUSY,
        output out_DONE,
        output out_COUNT
    );
endinterface

// File: rtl/shift_add_seq_ctrl.sv
// Shift-and-add multiplier sequencer.
//
//   state | meaning
//   IDLE  | waiting for in_START, step count held at 0
//   LOAD  | load operands, clear accumulator (one cycle)
//   CHECK | inspect multiplier LSB / zero flag, no strobe
//   ADD   | accumulate multiplicand (one cycle)
//   SHIFT | shift multiplier and product, one step done
//   DONE  | result valid, wait for in_START to drop
//
// Steps are tracked by a down-counter of remaining shifts; the host-visible
// step count is derived from it so it reads 0 in IDLE and WIDTH at the end.
// All outputs are decoded from registers only, so the negedge datapath sees
// strobes that were settled half a cycle earlier.
module shift_add_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int CNT_WIDTH  = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_seq_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_STEPS = CNT_WIDTH'(WIDTH);
    localparam logic [CNT_WIDTH-1:0] LP_ONE   = CNT_WIDTH'(1);
    localparam bit                   LP_EXIT  = (EARLY_EXIT != 0);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_remain;
    logic [CNT_WIDTH-1:0] w_remain_nxt;

    logic                 r_load;
    logic                 r_clr_acc;
    logic                 r_add;
    logic                 r_shift;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] r_count;

    logic                 w_last_step;
    logic                 w_exit_now;

    // The final SHIFT is the one that still has exactly one step remaining.
    assign w_last_step = (r_remain == LP_ONE);
    assign w_exit_now  = LP_EXIT && bus.in_ZERO;

    // State and remaining-step registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_remain <= LP_STEPS;
        end else begin
            r_state  <= w_state_nxt;
            r_remain <= w_remain_nxt;
        end
    end

    // Next-state and remaining-step decode.
    always_comb begin
        w_state_nxt  = S_IDLE;
        w_remain_nxt = r_remain;
        case (r_state)
            S_IDLE: begin
                w_remain_nxt = LP_STEPS;
                if (bus.in_START) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_remain_nxt = LP_STEPS;
                w_state_nxt  = S_CHECK;
            end
            S_CHECK: begin
                if (w_exit_now) begin
                    w_state_nxt = S_DONE;
                end else if (bus.in_LSB) begin
                    w_state_nxt = S_ADD;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_ADD: begin
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                // Guarded so the count can never run past WIDTH.
                if (r_remain != '0) begin
                    w_remain_nxt = r_remain - LP_ONE;
                end
                if (w_last_step || (r_remain == '0)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_DONE: begin
                if (bus.in_START) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt  = S_IDLE;
                    w_remain_nxt = LP_STEPS;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_remain_nxt = LP_STEPS;
            end
        endcase
    end

    // Moore output decode from state and counter registers.
    always_comb begin
        r_load    = 1'b0;
        r_clr_acc = 1'b0;
        r_add     = 1'b0;
        r_shift   = 1'b0;
        r_busy    = 1'b0;
        r_done    = 1'b0;
        r_count   = LP_STEPS - r_remain;
        case (r_state)
            S_IDLE: begin
                r_count = '0;
            end
            S_LOAD: begin
                r_load    = 1'b1;
                r_clr_acc = 1'b1;
                r_busy    = 1'b1;
            end
            S_CHECK: begin
                r_busy = 1'b1;
            end
            S_ADD: begin
                r_add  = 1'b1;
                r_busy = 1'b1;
            end
            S_SHIFT: begin
                r_shift = 1'b1;
                r_busy  = 1'b1;
            end
            S_DONE: begin
                r_done = 1'b1;
            end
            default: begin
                r_count = '0;
            end
        endcase
    end

    assign bus.out_LOAD    = r_load;
    assign bus.out_CLR_ACC = r_clr_acc;
    assign bus.out_ADD     = r_add;
    assign bus.out_SHIFT   = r_shift;
    assign bus.out_BUSY    = r_busy;
    assign bus.out_DONE    = r_done;
    assign bus.out_COUNT   = r_count;

endmodule

// File: tb/tb_shift_add_seq_ctrl.sv
// Bench for shift_add_seq_ctrl: two controllers (early exit off / on), each
// driving a behavioural negedge shift-and-add datapath. Results are checked
// against plain multiplication and a latency/pulse-count model.
module tb_shift_add_seq_ctrl;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         start_v = 2'b00;
    logic [W-1:0]       op_a [2];
    logic [W-1:0]       op_b [2];

    logic [1:0]         load_w, clr_w, add_w, shift_w, busy_w, done_w;
    logic [1:0][CW-1:0] cnt_w;
    logic [1:0][2*W-1:0] prod_w;

    int n_checks = 0;
    int n_fail   = 0;
    int n_add   [2];
    int n_shift [2];
    int n_load  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g
        logic [W-1:0]   mplier = '0;
        logic [2*W-1:0] mcand  = '0;
        logic [2*W-1:0] acc    = '0;

        shift_add_seq_ctrl_if #(.CNT_WIDTH(CW)) ifc ();

        shift_add_seq_ctrl #(.WIDTH(W), .CNT_WIDTH(CW), .EARLY_EXIT(gi)) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc.slave)
        );

        assign ifc.in_START = start_v[gi];
        assign ifc.in_LSB   = mplier[0];
        assign ifc.in_ZERO  = (mplier == '0);

        assign load_w[gi]  = ifc.out_LOAD;
        assign clr_w[gi]   = ifc.out_CLR_ACC;
        assign add_w[gi]   = ifc.out_ADD;
        assign shift_w[gi] = ifc.out_SHIFT;
        assign busy_w[gi]  = ifc.out_BUSY;
        assign done_w[gi]  = ifc.out_DONE;
        assign cnt_w[gi]   = ifc.out_COUNT;
        assign prod_w[gi]  = acc;

        always @(negedge clk) begin
            if (ifc.out_LOAD) begin
                mcand  <= {{W{1'b0}}, op_a[gi]};
                mplier <= op_b[gi];
            end
            if (ifc.out_CLR_ACC) acc <= '0;
            if (ifc.out_ADD)     acc <= acc + mcand;
            if (ifc.out_SHIFT) begin
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected edges (start edge counted as 1), ADD pulses and SHIFT steps.
    function automatic void ref_model(input bit ee, input logic [W-1:0] b,
                                      output int lat, output int adds, output int steps);
        lat = 2; adds = 0; steps = 0;
        for (int i = 0; i < W; i++) begin
            if (ee && ((b >> i) == 0)) begin
                lat++;
                return;
            end
            lat   += 2 + int'(b[i]);
            adds  += int'(b[i]);
            steps++;
        end
    endfunction

    // Advance one edge, sample 1 time unit later, check invariants, count strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("strobe_excl", 32'(int'(load_w[k]) + int'(add_w[k]) + int'(shift_w[k]) <= 1), 32'd1);
            chk("clr_without_load", 32'(clr_w[k] & ~load_w[k]), 32'd0);
            chk("busy_and_done", 32'(busy_w[k] & done_w[k]), 32'd0);
            chk("count_bound", 32'(int'(cnt_w[k]) <= W), 32'd1);
            n_add[k]   += int'(add_w[k]);
            n_shift[k] += int'(shift_w[k]);
            n_load[k]  += int'(load_w[k]);
        end
    endtask

    task automatic run_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit toggle_mid);
        int lat, adds, steps, edges;
        ref_model(k == 1, b, lat, adds, steps);
        op_a[k] = a;
        op_b[k] = b;
        n_add[k] = 0; n_shift[k] = 0; n_load[k] = 0;
        start_v[k] = 1'b1;
        tick();
        edges = 1;
        chk("load_after_start", 32'(load_w[k]), 32'd1);
        chk("clr_after_start",  32'(clr_w[k]),  32'd1);
        chk("busy_after_start", 32'(busy_w[k]), 32'd1);
        while (!done_w[k] && edges < 200) begin
            if (toggle_mid && edges == 4) start_v[k] = 1'b0;
            if (toggle_mid && edges == 6) start_v[k] = 1'b1;
            tick();
            edges++;
        end
        chk("done_latency", 32'(edges), 32'(lat));
        chk("done_busy_low", 32'(busy_w[k]), 32'd0);
        chk("final_count", 32'(cnt_w[k]), 32'(steps));
        chk("add_pulses", 32'(n_add[k]), 32'(adds));
        chk("shift_pulses", 32'(n_shift[k]), 32'(steps));
        chk("product", 32'(prod_w[k]), 32'(int'(a) * int'(b)));
        start_v[k] = 1'b1;
        repeat (3) tick();
        chk("done_held", 32'(done_w[k]), 32'd1);
        chk("no_restart", 32'(n_load[k]), 32'd1);
        chk("count_held", 32'(cnt_w[k]), 32'(steps));
        start_v[k] = 1'b0;
        tick();
        chk("idle_done", 32'(done_w[k]), 32'd0);
        chk("idle_busy", 32'(busy_w[k]), 32'd0);
        chk("idle_count", 32'(cnt_w[k]), 32'd0);
    endtask

    initial begin
        int guard;
        logic [4:0] seq_exp [6];
        logic [W-1:0] ra, rb;

        op_a[0] = '0; op_a[1] = '0; op_b[0] = '0; op_b[1] = '0;
        n_add   = '{0, 0}; n_shift = '{0, 0}; n_load = '{0, 0};

        rst = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_strobes", 32'({load_w[k], clr_w[k], add_w[k], shift_w[k]}), 32'd0);
            chk("rst_busy_done", 32'({busy_w[k], done_w[k]}), 32'd0);
            chk("rst_count", 32'(cnt_w[k]), 32'd0);
        end
        rst = 1'b1;
        tick();
        chk("idle_no_start", 32'(busy_w[0] | busy_w[1]), 32'd0);

        run_op(0, 8'h5A, 8'hB5, 1'b0);
        run_op(0, 8'h37, 8'h00, 1'b0);
        run_op(1, 8'h37, 8'h00, 1'b0);
        run_op(0, 8'hFF, 8'hFF, 1'b1);
        run_op(1, 8'hC3, 8'hB5, 1'b1);

        // Early-exit walk with multiplier 1: LOAD CHECK ADD SHIFT CHECK DONE.
        // Pattern bits: {load, add, shift, busy, done}.
        seq_exp[0] = 5'b10010;
        seq_exp[1] = 5'b00010;
        seq_exp[2] = 5'b01010;
        seq_exp[3] = 5'b00110;
        seq_exp[4] = 5'b00010;
        seq_exp[5] = 5'b00001;
        op_a[1] = 8'h2D;
        op_b[1] = 8'h01;
        start_v[1] = 1'b1;
        for (int s = 0; s < 6; s++) begin
            tick();
            chk("ee_one_seq", 32'({load_w[1], add_w[1], shift_w[1], busy_w[1], done_w[1]}),
                32'(seq_exp[s]));
        end
        chk("ee_one_count", 32'(cnt_w[1]), 32'd1);
        chk("ee_one_product", 32'(prod_w[1]), 32'h2D);
        start_v[1] = 1'b0;
        tick();
        chk("ee_one_idle", 32'(done_w[1]), 32'd0);

        // Reset in the middle of the 4th SHIFT.
        op_a[0] = 8'h81;
        op_b[0] = 8'hFF;
        n_shift[0] = 0;
        start_v[0] = 1'b1;
        tick();
        guard = 0;
        while (!(shift_w[0] && n_shift[0] == 4) && guard < 100) begin
            tick();
            guard++;
        end
        chk("reached_4th_shift", 32'(shift_w[0] && n_shift[0] == 4), 32'd1);
        rst = 1'b0;
        start_v[0] = 1'b0;
        tick();
        chk("midrst_strobes", 32'({load_w[0], clr_w[0], add_w[0], shift_w[0]}), 32'd0);
        chk("midrst_busy_done", 32'({busy_w[0], done_w[0]}), 32'd0);
        chk("midrst_count", 32'(cnt_w[0]), 32'd0);
        rst = 1'b1;
        tick();
        run_op(0, 8'h81, 8'hFF, 1'b0);

        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
            run_op(i % 2, ra, rb, (i % 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
